// File: rtl/jtag_types_pkg.sv
// jtag_types_pkg: shared types and constants for the AP request bridge
package jtag_types_pkg;
  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 8;
  localparam int RNW_WIDTH  = 1;
  localparam int REQ_WIDTH  = DATA_WIDTH + ADDR_WIDTH + RNW_WIDTH;
  localparam int PEND_MAX   = 4;
  typedef enum logic [1:0] {
    ACK_NONE = 2'b00,
    ACK_WAIT = 2'b01,
    ACK_OK   = 2'b10
  } ack_e;
  typedef enum logic [1:0] {
    S_IDLE,
    S_PUSH,
    S_POP
  } state_e;
  // all-ones address/data with rnw=0 clears the sticky overrun instead of pushing
  localparam logic [REQ_WIDTH-1:0] CLEAR_CMD = {{(REQ_WIDTH-1){1'b1}}, 1'b0};
endpackage

// File: rtl/ap_req_bridge.sv
// ap_req_bridge: JTAG DR scan register bridging AP requests into a request FIFO
// and read responses back out of a response FIFO, with pending-read accounting.
module ap_req_bridge
  import jtag_types_pkg::*;
#(
  parameter int DATA_W   = DATA_WIDTH,
  parameter int ADDR_W   = ADDR_WIDTH,
  parameter int MAX_PEND = PEND_MAX
) (
  input  logic                       CLK,
  input  logic                       rst,
  input  logic                       ap_sel,
  input  logic                       capture_dr,
  input  logic                       shift_dr,
  input  logic                       update_dr,
  input  logic                       tdi,
  output logic                       tdo,
  input  logic                       wfull,
  output logic                       winc,
  output logic [DATA_W+ADDR_W:0]     wdata_fifo1,
  input  logic                       rempty,
  output logic                       rinc,
  input  logic [DATA_W-1:0]          rdata_fifo2
);
  localparam int REQ_W = DATA_W + ADDR_W + 1;
  state_e           state_q;
  logic [REQ_W-1:0] sr_q;
  logic [REQ_W-1:0] wdata_q;
  logic [2:0]       pend_q;
  logic             ovr_q;
  logic             winc_q;
  logic             rinc_q;
  logic             is_clear;
  logic             can_push;
  ack_e             ack;
  logic [DATA_W-1:0] rsp;
  assign tdo         = ap_sel & sr_q[0];
  assign winc        = winc_q;
  assign rinc        = rinc_q;
  assign wdata_fifo1 = wdata_q;
  always_comb begin
    is_clear = sr_q == {{(REQ_W-1){1'b1}}, 1'b0};
    can_push = !wfull && !(sr_q[0] && pend_q == 3'(MAX_PEND));
    ack      = pend_q == 3'd0 ? ACK_NONE : rempty ? ACK_WAIT : ACK_OK;
    rsp      = ack == ACK_OK ? rdata_fifo2 : '0;
  end
  // PUSH/POP always finish their single-cycle strobe so a FIFO never sees a stretched pulse
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      sr_q    <= '0;
      wdata_q <= '0;
      pend_q  <= '0;
      ovr_q   <= 1'b0;
      winc_q  <= 1'b0;
      rinc_q  <= 1'b0;
    end else begin
      case (state_q)
        S_PUSH: begin
          winc_q  <= 1'b0;
          pend_q  <= pend_q + {2'b00, wdata_q[0]};
          state_q <= S_IDLE;
        end
        S_POP: begin
          rinc_q  <= 1'b0;
          pend_q  <= pend_q - 3'd1;
          state_q <= S_IDLE;
        end
        default: begin
          if (ap_sel) begin
            if (update_dr) begin
              if (is_clear) begin
                ovr_q <= 1'b0;
              end else if (can_push) begin
                wdata_q <= sr_q;
                winc_q  <= 1'b1;
                state_q <= S_PUSH;
              end else begin
                ovr_q <= 1'b1;
              end
            end else if (capture_dr) begin
              sr_q <= {rsp, {(ADDR_W-2){1'b0}}, ovr_q, ack};
              if (ack == ACK_OK) begin
                rinc_q  <= 1'b1;
                state_q <= S_POP;
              end
            end else if (shift_dr) begin
              sr_q <= {tdi, sr_q[REQ_W-1:1]};
            end
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_ap_req_bridge.sv
// tb_ap_req_bridge: directed transaction-level checks of ap_req_bridge
module tb_ap_req_bridge;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ap_sel = 1'b1;
  logic        capture_dr = 1'b0, shift_dr = 1'b0, update_dr = 1'b0, tdi = 1'b0;
  logic        tdo;
  logic        wfull = 1'b0, winc;
  logic [40:0] wdata_fifo1;
  logic        rempty = 1'b1, rinc;
  logic [31:0] rdata_fifo2 = 32'h0;

  ap_req_bridge dut (
    .CLK(clk), .rst(rst), .ap_sel(ap_sel), .capture_dr(capture_dr), .shift_dr(shift_dr),
    .update_dr(update_dr), .tdi(tdi), .tdo(tdo), .wfull(wfull), .winc(winc),
    .wdata_fifo1(wdata_fifo1), .rempty(rempty), .rinc(rinc), .rdata_fifo2(rdata_fifo2)
  );

  always #5 clk = ~clk;

  localparam logic [40:0] CLR = {{40{1'b1}}, 1'b0};
  logic [40:0] m_sr = '0;
  int          m_pend = 0;
  bit          m_ovr = 0;
  bit          exp_winc = 0, exp_rinc = 0;
  logic [40:0] exp_wdata = '0;
  int          total = 0, bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h @%0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      chk("cyc_winc", 64'(winc), 64'(exp_winc));
      chk("cyc_rinc", 64'(rinc), 64'(exp_rinc));
      chk("cyc_tdo", 64'(tdo), 64'(ap_sel & m_sr[0]));
      if (exp_winc) chk("cyc_wdata", 64'(wdata_fifo1), 64'(exp_wdata));
    end
  end

  task automatic shift(input logic [40:0] w, output logic [40:0] o);
    for (int i = 0; i < 41; i++) begin
      tdi = w[i];
      shift_dr = 1'b1;
      @(negedge clk);
      o[i] = tdo;
      @(posedge clk); #1;
      if (ap_sel) m_sr = {w[i], m_sr[40:1]};
    end
    shift_dr = 1'b0;
    tdi = 1'b0;
  endtask

  task automatic upd(output bit seen, output logic [40:0] wd);
    update_dr = 1'b1;
    @(posedge clk); #1;
    update_dr = 1'b0;
    if (ap_sel) begin
      if (m_sr == CLR) m_ovr = 0;
      else if (!wfull && !(m_sr[0] && m_pend == 4)) begin
        exp_winc = 1;
        exp_wdata = m_sr;
      end else m_ovr = 1;
    end
    @(negedge clk);
    seen = winc;
    wd = wdata_fifo1;
    @(posedge clk); #1;
    if (exp_winc) begin
      m_pend += int'(exp_wdata[0]);
      exp_winc = 0;
    end
  endtask

  task automatic cap(output bit seen);
    capture_dr = 1'b1;
    @(posedge clk); #1;
    capture_dr = 1'b0;
    if (ap_sel) begin
      if (m_pend == 0) m_sr = {32'h0, 6'h0, m_ovr, 2'b00};
      else if (rempty) m_sr = {32'h0, 6'h0, m_ovr, 2'b01};
      else begin
        m_sr = {rdata_fifo2, 6'h0, m_ovr, 2'b10};
        exp_rinc = 1;
      end
    end
    @(negedge clk);
    seen = rinc;
    @(posedge clk); #1;
    if (exp_rinc) begin
      m_pend--;
      exp_rinc = 0;
      rempty = 1'b1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    bit          s;
    logic [40:0] o, wd, w;
    int          n, okc;
    #2 rst = 1'b1;
    #1;
    chk("rst_winc", 64'(winc), 0);
    chk("rst_rinc", 64'(rinc), 0);
    chk("rst_tdo", 64'(tdo), 0);
    chk("rst_wdata", 64'(wdata_fifo1), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    // plain write
    shift(41'h1BD5B7DDE08, o);
    upd(s, wd);
    chk("wr_winc", 64'(s), 1);
    chk("wr_data", 64'(wd), 64'h1BD5B7DDE08);
    cap(s);
    chk("wr_no_rinc", 64'(s), 0);
    shift('0, o);
    chk("wr_pend0_ack", 64'(o), 0);
    // read round trip
    shift(41'h21, o);
    upd(s, wd);
    chk("rd_winc", 64'(s), 1);
    rdata_fifo2 = 32'hCAFEF00D;
    rempty = 1'b0;
    cap(s);
    chk("rd_rinc", 64'(s), 1);
    shift('0, o);
    chk("rd_resp", 64'(o), 64'h195FDE01A02);
    cap(s);
    shift('0, o);
    chk("rd_drained", 64'(o), 0);
    // response not ready
    shift(41'h41, o);
    upd(s, wd);
    cap(s);
    chk("nr_rinc", 64'(s), 0);
    shift('0, o);
    chk("nr_ack", 64'(o), 1);
    rdata_fifo2 = 32'h12345678;
    rempty = 1'b0;
    cap(s);
    chk("nr_late_rinc", 64'(s), 1);
    shift('0, o);
    chk("nr_late_resp", 64'(o), 64'h2468ACF002);
    // request FIFO full -> overrun, then clear
    wfull = 1'b1;
    shift(41'h1BD5B7DDE08, o);
    upd(s, wd);
    chk("full_winc", 64'(s), 0);
    wfull = 1'b0;
    cap(s);
    shift('0, o);
    chk("full_ovr", 64'(o), 64'h4);
    shift(CLR, o);
    upd(s, wd);
    chk("clr_winc", 64'(s), 0);
    cap(s);
    shift('0, o);
    chk("clr_ovr", 64'(o), 0);
    // pending limit
    n = 0;
    for (int k = 0; k < 5; k++) begin
      w = {32'h0, 8'(k + 1), 1'b1};
      shift(w, o);
      upd(s, wd);
      n += int'(s);
    end
    chk("lim_pushes", 64'(n), 4);
    okc = 0;
    for (int k = 0; k < 5; k++) begin
      rdata_fifo2 = 32'hA5A50000 | 32'(k);
      rempty = 1'b0;
      cap(s);
      shift('0, o);
      if (o[1:0] == 2'b10) okc++;
      if (k == 0) chk("lim_ovr", 64'(o[2]), 1);
    end
    rempty = 1'b1;
    chk("lim_pops", 64'(okc), 4);
    shift(CLR, o);
    upd(s, wd);
    // ap_sel gating
    ap_sel = 1'b0;
    shift(41'h1BD5B7DDE08, o);
    chk("sel_tdo", 64'(o), 0);
    upd(s, wd);
    chk("sel_winc", 64'(s), 0);
    ap_sel = 1'b1;
    // reset in the PUSH cycle
    shift(41'h21, o);
    upd(s, wd);
    shift(41'h1BD5B7DDE08, o);
    update_dr = 1'b1;
    @(posedge clk); #1;
    update_dr = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_winc", 64'(winc), 0);
    chk("mid_rst_wdata", 64'(wdata_fifo1), 0);
    chk("mid_rst_tdo", 64'(tdo), 0);
    m_sr = '0;
    m_pend = 0;
    m_ovr = 0;
    exp_winc = 0;
    exp_rinc = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    cap(s);
    chk("mid_rst_rinc", 64'(s), 0);
    shift('0, o);
    chk("mid_rst_pend", 64'(o), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
